// File: rtl/mmt_sync_pkg.sv
// Shared types and constants for the mmt synchronizer / event capture blocks.
package mmt_sync_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        QUAL   = 1'b1
    } mmt_evt_state_e;

    localparam int MMT_EDGE_RISE = 0;
    localparam int MMT_EDGE_FALL = 1;
    localparam int MMT_EDGE_BOTH = 2;

    // True when an edge toward level `rise` is reported under edge selection `edge_sel`.
    function automatic logic mmt_edge_allowed(input int edge_sel, input logic rise);
        return (edge_sel == MMT_EDGE_BOTH) ||
               (rise  && (edge_sel == MMT_EDGE_RISE)) ||
               (!rise && (edge_sel == MMT_EDGE_FALL));
    endfunction

endpackage

// File: rtl/mmt_sync_single.sv
// Multi-flop level synchronizer for one asynchronous bit into the clk domain.
module mmt_sync_single #(
    parameter int Depth      = 2,
    parameter bit AsyncReset = 1'b1,
    parameter bit AsyncSet   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic a,
    output logic s
);

    localparam logic [Depth-1:0] RstVal = {Depth{AsyncSet}};

    logic [Depth-1:0] sync_q;

    generate
        if (AsyncReset || AsyncSet) begin : g_async
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) sync_q <= RstVal;
                else       sync_q <= {sync_q[Depth-2:0], a};
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (!rstn) sync_q <= RstVal;
                else       sync_q <= {sync_q[Depth-2:0], a};
            end
        end
    endgenerate

    assign s = sync_q[Depth-1];

endmodule

// File: rtl/mmt_sync_event_cap.sv
// Synchronize, debounce and edge-detect an async level; present edges as a
// one-entry valid/ready event with a saturating counter and sticky overflow.
module mmt_sync_event_cap
    import mmt_sync_pkg::*;
#(
    parameter int Depth          = 3,
    parameter int DebounceCycles = 4,
    parameter int EdgeSel        = 2,
    parameter int CntWidth       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                async_in,
    output logic                level_out,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic                evt_rise,
    output logic [CntWidth-1:0] evt_count,
    output logic                evt_ovf,
    input  logic                cnt_clr
);

    localparam int DW = $clog2(DebounceCycles + 1);
    localparam logic [DW-1:0] DLast = DW'(DebounceCycles - 1);

    generate
        if (Depth < 2)          begin : g_chk_depth $error("Depth must be >= 2"); end
        if (DebounceCycles < 1) begin : g_chk_db    $error("DebounceCycles must be >= 1"); end
        if (EdgeSel > 2)        begin : g_chk_es    $error("EdgeSel must be <= 2"); end
        if (CntWidth < 2)       begin : g_chk_cw    $error("CntWidth must be >= 2"); end
    endgenerate

    logic s;

    mmt_sync_single #(
        .Depth      (Depth),
        .AsyncReset (1'b1),
        .AsyncSet   (1'b0)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .a    (async_in),
        .s    (s)
    );

    mmt_evt_state_e state;
    logic [DW-1:0]  dcnt;
    logic           lvl;
    logic           fire;
    logic           report;
    logic           load;
    logic           drop;

    // An edge fires on the cycle the new level completes its qualification run.
    always_comb begin
        fire   = (s != lvl) && ((DebounceCycles == 1) || ((state == QUAL) && (dcnt == DLast)));
        report = fire && mmt_edge_allowed(EdgeSel, s);
        load   = report && (!evt_valid || evt_ready);
        drop   = report && evt_valid && !evt_ready;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= STABLE;
            dcnt  <= '0;
            lvl   <= 1'b0;
        end else begin
            case (state)
                STABLE: begin
                    if (s == lvl) begin
                        dcnt <= '0;
                    end else if (DebounceCycles == 1) begin
                        lvl <= s;
                    end else begin
                        state <= QUAL;
                        dcnt  <= DW'(1);
                    end
                end
                QUAL: begin
                    if (s == lvl) begin
                        state <= STABLE;
                        dcnt  <= '0;
                    end else if (dcnt == DLast) begin
                        lvl   <= s;
                        state <= STABLE;
                        dcnt  <= '0;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                default: begin
                    state <= STABLE;
                    dcnt  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            evt_valid <= 1'b0;
            evt_rise  <= 1'b0;
            evt_count <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            if (load) begin
                evt_valid <= 1'b1;
                evt_rise  <= s;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            // A coincident clear still counts the edge reported in the same cycle.
            if (cnt_clr)
                evt_count <= {{(CntWidth-1){1'b0}}, report};
            else if (report && (evt_count != '1))
                evt_count <= evt_count + CntWidth'(1);

            if (drop)         evt_ovf <= 1'b1;
            else if (cnt_clr) evt_ovf <= 1'b0;
        end
    end

    assign level_out = lvl;

endmodule

// File: tb/tb_mmt_sync_event_cap.sv
// Randomized scoreboard bench: three DUT configurations share one stimulus
// stream, each with a sample-history reference model and an event queue.
module tb_mmt_sync_event_cap;

    localparam int NCFG = 3;

    function automatic int cfg_depth(input int i);
        return (i == 2) ? 2 : 3;
    endfunction
    function automatic int cfg_dc(input int i);
        return (i == 2) ? 1 : 4;
    endfunction
    function automatic int cfg_es(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 1;
        endcase
    endfunction
    function automatic int cfg_cw(input int i);
        return (i == 1) ? 2 : 8;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn      = 1'b1;
    logic async_in  = 1'b0;
    logic evt_ready = 1'b0;
    logic cnt_clr   = 1'b0;

    int checks = 0;
    int errors = 0;
    bit drained = 1'b0;

    task automatic chk(input int g, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s got %0d expected %0d at %0t", g, name, act, exp, $time);
        end
    endtask

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_cfg
            localparam int D  = cfg_depth(g);
            localparam int DC = cfg_dc(g);
            localparam int ES = cfg_es(g);
            localparam int CW = cfg_cw(g);

            logic          level_out;
            logic          evt_valid;
            logic          evt_rise;
            logic          evt_ovf;
            logic [CW-1:0] evt_count;

            mmt_sync_event_cap #(
                .Depth          (D),
                .DebounceCycles (DC),
                .EdgeSel        (ES),
                .CntWidth       (CW)
            ) dut (
                .clk       (clk),
                .rstn      (rstn),
                .async_in  (async_in),
                .level_out (level_out),
                .evt_valid (evt_valid),
                .evt_ready (evt_ready),
                .evt_rise  (evt_rise),
                .evt_count (evt_count),
                .evt_ovf   (evt_ovf),
                .cnt_clr   (cnt_clr)
            );

            // Reference: s is async_in as sampled D edges earlier; the level flips
            // once the last DC samples of s all disagree with it.
            bit ain_hist[$];
            bit s_hist[$];
            bit exp_q[$];
            bit m_lvl   = 1'b0;
            bit m_valid = 1'b0;
            bit m_ovf   = 1'b0;
            int m_cnt   = 0;

            always @(posedge clk or negedge rstn) begin : model
                bit s_now, fire, allowed, rep, drop;
                if (!rstn) begin
                    ain_hist = {};
                    repeat (D) ain_hist.push_back(1'b0);
                    s_hist  = {};
                    exp_q   = {};
                    m_lvl   = 1'b0;
                    m_valid = 1'b0;
                    m_ovf   = 1'b0;
                    m_cnt   = 0;
                end else begin
                    s_now = ain_hist[0];
                    ain_hist.push_back(async_in);
                    void'(ain_hist.pop_front());
                    s_hist.push_back(s_now);
                    if (s_hist.size() > DC) void'(s_hist.pop_front());
                    fire = (s_hist.size() == DC);
                    foreach (s_hist[i]) if (s_hist[i] == m_lvl) fire = 1'b0;
                    if (fire) m_lvl = s_now;
                    allowed = (ES == 2) || (ES == 0 && s_now) || (ES == 1 && !s_now);
                    rep  = fire && allowed;
                    drop = rep && m_valid && !evt_ready;
                    if (rep && !drop) begin
                        m_valid = 1'b1;
                        exp_q.push_back(s_now);
                    end else if (m_valid && evt_ready) begin
                        m_valid = 1'b0;
                    end
                    if (cnt_clr) m_cnt = rep ? 1 : 0;
                    else if (rep && m_cnt < (1 << CW) - 1) m_cnt++;
                    m_ovf = (m_ovf && !cnt_clr) || drop;
                end
            end

            always @(negedge clk) begin : monitor
                chk(g, "level_out", int'(level_out), int'(m_lvl));
                chk(g, "evt_valid", int'(evt_valid), int'(m_valid));
                chk(g, "evt_count", int'(evt_count), m_cnt);
                chk(g, "evt_ovf", int'(evt_ovf), int'(m_ovf));
                if (evt_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(g, "evt_unexpected", 1, 0);
                    end else begin
                        chk(g, "evt_rise", int'(evt_rise), int'(exp_q[0]));
                        if (evt_ready) void'(exp_q.pop_front());
                    end
                end
            end

            initial begin
                wait (drained);
                chk(g, "events_left", exp_q.size(), 0);
            end
        end
    endgenerate

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : stim
        int hold;
        #1 rstn = 1'b0;
        step(3);
        rstn = 1'b1;

        // Rise with consumer ready
        evt_ready = 1'b1;
        async_in  = 1'b1;
        step(12);
        async_in  = 1'b0;
        step(12);

        // Glitches of 3 and 4 cycles
        async_in = 1'b1; step(3);
        async_in = 1'b0; step(12);
        async_in = 1'b1; step(4);
        async_in = 1'b0; step(12);

        // Back-pressure: rise then fall with nobody accepting
        evt_ready = 1'b0;
        async_in  = 1'b1; step(10);
        async_in  = 1'b0; step(10);
        evt_ready = 1'b1; step(1);
        evt_ready = 1'b0; step(3);

        // Saturation, then a clear aimed at a reported edge
        evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            async_in = ~async_in;
            step(9);
        end
        async_in = ~async_in;
        step(6);
        cnt_clr = 1'b1; step(1);
        cnt_clr = 1'b0; step(10);

        // Reset while qualifying, released with input high
        async_in = 1'b0; step(10);
        async_in = 1'b1; step(5);
        rstn = 1'b0; step(2);
        rstn = 1'b1; step(12);

        // Random phase
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                async_in = 1'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            evt_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 19) == 0);
            rstn      = ($urandom_range(0, 399) != 0);
            step(1);
        end

        // Drain pending events
        rstn      = 1'b1;
        cnt_clr   = 1'b0;
        evt_ready = 1'b1;
        step(20);
        drained = 1'b1;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
